// File: rtl/alu_result_stage.sv
// EX->MEM result stage: waits out multi-cycle ALU ops, 2-entry result FIFO, HI/LO owner.
// Optional HI/LO registers: define ALU_RESULT_STAGE_HILO_EN.
module alu_result_stage #(
  parameter int DEPTH    = 2,
  parameter int OV_CNT_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [4:0]          in_rd,
  input  logic                in_wr_en,
  input  logic                in_hilo_wr,
  input  logic                EX_Flush,
  input  logic [31:0]         Result,
  input  logic                BZero,
  input  logic                EXC_Ov,
  input  logic                ALU_Stall,
  input  logic [31:0]         out_HI,
  input  logic [31:0]         out_LO,
  output logic                EX_Stall,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [31:0]         m_result,
  output logic [4:0]          m_rd,
  output logic                m_wr_en,
  output logic                m_bzero,
  output logic                exc_pulse,
  output logic [OV_CNT_W-1:0] ov_count,
  output logic [31:0]         hi_reg,
  output logic [31:0]         lo_reg
);

  typedef enum logic {IDLE, WAIT} state_e;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wr;
    logic        bz;
  } ent_t;

  localparam logic [1:0] FULL = 2'(DEPTH);

  state_e              state_q, state_d;
  logic [4:0]          rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                hilo_q, hilo_d;
  logic [1:0]          count_q;
  ent_t                ent0_q, ent1_q;
  logic                exc_q;
  logic [OV_CNT_W-1:0] ov_q;

  logic       cap;
  logic [4:0] cap_rd;
  logic       cap_wr;
  logic       cap_hilo;
  logic       push;
  logic       ovf;
  logic       pop;
  ent_t       new_ent;

  assign EX_Stall = (state_q == WAIT) || (count_q == FULL);
  assign m_valid  = (count_q != 2'd0);
  assign m_result = ent0_q.res;
  assign m_rd     = ent0_q.rd;
  assign m_wr_en  = ent0_q.wr;
  assign m_bzero  = ent0_q.bz;
  assign exc_pulse = exc_q;
  assign ov_count  = ov_q;

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    hilo_d   = hilo_q;
    cap      = 1'b0;
    cap_rd   = in_rd;
    cap_wr   = in_wr_en;
    cap_hilo = in_hilo_wr;
    case (state_q)
      IDLE: begin
        if (in_valid && !EX_Stall && !EX_Flush) begin
          if (ALU_Stall) begin
            state_d = WAIT;
            rd_d    = in_rd;
            wr_d    = in_wr_en;
            hilo_d  = in_hilo_wr;
          end else begin
            cap = 1'b1;
          end
        end
      end
      WAIT: begin
        cap_rd   = rd_q;
        cap_wr   = wr_q;
        cap_hilo = hilo_q;
        // Flush wins over a completion on the same edge
        if (EX_Flush) begin
          state_d = IDLE;
        end else if (!ALU_Stall && count_q < FULL) begin
          cap     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push    = cap && !EXC_Ov;
  assign ovf     = cap && EXC_Ov;
  assign pop     = m_valid && m_ready;
  assign new_ent = '{res: Result, rd: cap_rd, wr: cap_wr, bz: BZero};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      hilo_q  <= 1'b0;
      exc_q   <= 1'b0;
      ov_q    <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      hilo_q  <= hilo_d;
      exc_q   <= ovf;
      if (ovf && ov_q != '1) ov_q <= ov_q + 1'b1;
    end
  end

  // Push only happens below FULL, so push+pop implies exactly one entry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) ent0_q <= new_ent;
          else                 ent1_q <= new_ent;
        end
        2'b01:   ent0_q <= ent1_q;
        2'b11:   ent0_q <= new_ent;
        default: ;
      endcase
    end
  end

`ifdef ALU_RESULT_STAGE_HILO_EN
  logic [31:0] hi_q, lo_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (push && cap_hilo) begin
      hi_q <= out_HI;
      lo_q <= out_LO;
    end
  end

  assign hi_reg = hi_q;
  assign lo_reg = lo_q;
`else
  logic unused_hilo;
  assign unused_hilo = ^{out_HI, out_LO, cap_hilo};
  assign hi_reg = '0;
  assign lo_reg = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed vectors, queue-based head checking.
module tb_alu_result_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_wr_en, in_hilo_wr, EX_Flush;
  logic [4:0]  in_rd;
  logic [31:0] Result, out_HI, out_LO;
  logic        BZero, EXC_Ov, ALU_Stall, m_ready;
  logic        EX_Stall, m_valid, m_wr_en, m_bzero, exc_pulse;
  logic [31:0] m_result, hi_reg, lo_reg;
  logic [4:0]  m_rd;
  logic [7:0]  ov_count;

  int checks = 0;
  int errors = 0;

  logic [38:0] sb[$];
  logic [31:0] exp_hi, exp_lo;

  alu_result_stage #(.DEPTH(2), .OV_CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_rd(in_rd), .in_wr_en(in_wr_en),
    .in_hilo_wr(in_hilo_wr), .EX_Flush(EX_Flush),
    .Result(Result), .BZero(BZero), .EXC_Ov(EXC_Ov),
    .ALU_Stall(ALU_Stall), .out_HI(out_HI), .out_LO(out_LO),
    .EX_Stall(EX_Stall), .m_valid(m_valid), .m_ready(m_ready),
    .m_result(m_result), .m_rd(m_rd), .m_wr_en(m_wr_en),
    .m_bzero(m_bzero), .exc_pulse(exc_pulse), .ov_count(ov_count),
    .hi_reg(hi_reg), .lo_reg(lo_reg)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_push(input logic [31:0] r, input logic [4:0] rd,
                             input logic wr, input logic bz);
    sb.push_back({r, rd, wr, bz});
  endtask

  // Monitor: every handshake must match the oldest expected entry
  always @(negedge clock) begin
    if (!reset && m_valid && m_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL head_unexpected: got %h/%0d with nothing expected",
                 m_result, m_rd);
      end else begin
        logic [38:0] e;
        e = sb.pop_front();
        if ({m_result, m_rd, m_wr_en, m_bzero} !== e) begin
          errors++;
          $display("FAIL head: got %h expected %h",
                   {m_result, m_rd, m_wr_en, m_bzero}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    in_valid = 0; in_rd = 0; in_wr_en = 0; in_hilo_wr = 0; EX_Flush = 0;
    Result = 0; BZero = 0; EXC_Ov = 0; ALU_Stall = 0;
    out_HI = 0; out_LO = 0; m_ready = 0;
    tick; tick;
    chk("rst_stall", {31'b0, EX_Stall}, 0);
    chk("rst_mvalid", {31'b0, m_valid}, 0);
    chk("rst_mresult", m_result, 0);
    chk("rst_exc", {31'b0, exc_pulse}, 0);
    chk("rst_ovcnt", {24'b0, ov_count}, 0);
    chk("rst_hi", hi_reg, 0);
    chk("rst_lo", lo_reg, 0);
    reset = 1'b0;
    tick;

    // Single add
    m_ready = 1; in_valid = 1; Result = 32'h5; in_rd = 3; in_wr_en = 1;
    expect_push(32'h5, 5'd3, 1'b1, 1'b0);
    tick;
    in_valid = 0;
    chk("add_mvalid", {31'b0, m_valid}, 1);
    chk("add_rd", {27'b0, m_rd}, 3);
    chk("add_stall", {31'b0, EX_Stall}, 0);
    tick;
    chk("add_drained", {31'b0, m_valid}, 0);

    // Multiply: 32 cycles of ALU_Stall
    in_valid = 1; in_rd = 0; in_wr_en = 0; in_hilo_wr = 1;
    ALU_Stall = 1; Result = 32'h1234;
    tick;
    in_valid = 0; in_hilo_wr = 0;
    for (int i = 0; i < 31; i++) begin
      chk("mult_stall", {31'b0, EX_Stall}, 1);
      tick;
    end
    chk("mult_noval", {31'b0, m_valid}, 0);
    ALU_Stall = 0; out_HI = 32'h1; out_LO = 32'hFFFF_FFFE;
    expect_push(32'h1234, 5'd0, 1'b0, 1'b0);
    tick;
`ifdef ALU_RESULT_STAGE_HILO_EN
    exp_hi = 32'h1; exp_lo = 32'hFFFF_FFFE;
`else
    exp_hi = 32'h0; exp_lo = 32'h0;
`endif
    chk("mult_hi", hi_reg, exp_hi);
    chk("mult_lo", lo_reg, exp_lo);
    chk("mult_mvalid", {31'b0, m_valid}, 1);
    chk("mult_wr", {31'b0, m_wr_en}, 0);
    chk("mult_unstall", {31'b0, EX_Stall}, 0);
    tick;

    // Backpressure: three adds with m_ready low
    m_ready = 0; in_valid = 1; in_wr_en = 1; BZero = 1;
    Result = 32'hA0; in_rd = 5; expect_push(32'hA0, 5'd5, 1'b1, 1'b1);
    tick;
    chk("bp_stall1", {31'b0, EX_Stall}, 0);
    BZero = 0; Result = 32'hB0; in_rd = 6;
    expect_push(32'hB0, 5'd6, 1'b1, 1'b0);
    tick;
    chk("bp_full", {31'b0, EX_Stall}, 1);
    Result = 32'hC0; in_rd = 7; expect_push(32'hC0, 5'd7, 1'b1, 1'b0);
    tick;
    chk("bp_held", {31'b0, EX_Stall}, 1);
    chk("bp_head", m_result, 32'hA0);
    m_ready = 1;
    tick;
    chk("bp_release", {31'b0, EX_Stall}, 0);
    tick;
    in_valid = 0;
    chk("bp_third", m_result, 32'hC0);
    tick;
    chk("bp_empty", {31'b0, m_valid}, 0);

    // Overflow captures
    in_valid = 1; EXC_Ov = 1; Result = 32'h8000_0000; in_rd = 9;
    tick;
    in_valid = 0; EXC_Ov = 0;
    chk("ov_pulse", {31'b0, exc_pulse}, 1);
    chk("ov_cnt1", {24'b0, ov_count}, 1);
    chk("ov_novalid", {31'b0, m_valid}, 0);
    tick;
    chk("ov_pulse_end", {31'b0, exc_pulse}, 0);
    in_valid = 1; EXC_Ov = 1;
    for (int i = 0; i < 299; i++) begin
      tick;
      if (i == 1) chk("ov_b2b", {31'b0, exc_pulse}, 1);
    end
    in_valid = 0; EXC_Ov = 0;
    chk("ov_sat", {24'b0, ov_count}, 255);
    tick;
    chk("ov_sat_end", {31'b0, exc_pulse}, 0);
    chk("ov_sat_hold", {24'b0, ov_count}, 255);

    // Flush in IDLE
    in_valid = 1; EX_Flush = 1; Result = 32'hDEAD; in_rd = 2;
    tick;
    in_valid = 0; EX_Flush = 0;
    chk("flush_idle", {31'b0, m_valid}, 0);

    // Flush in WAIT, same edge as completion
    in_valid = 1; in_hilo_wr = 1; ALU_Stall = 1;
    out_HI = 32'hAAAA; out_LO = 32'h5555;
    tick;
    in_valid = 0; in_hilo_wr = 0;
    tick;
    chk("fw_wait", {31'b0, EX_Stall}, 1);
    EX_Flush = 1; ALU_Stall = 0;
    tick;
    EX_Flush = 0;
    chk("fw_idle", {31'b0, EX_Stall}, 0);
    chk("fw_hi", hi_reg, exp_hi);
    chk("fw_lo", lo_reg, exp_lo);
    chk("fw_nopush", {31'b0, m_valid}, 0);
    tick;
    chk("fw_nopush2", {31'b0, m_valid}, 0);

    // Reset during WAIT with one FIFO entry
    m_ready = 0; in_valid = 1; in_wr_en = 1; Result = 32'h77; in_rd = 4;
    expect_push(32'h77, 5'd4, 1'b1, 1'b0);
    tick;
    in_hilo_wr = 1; ALU_Stall = 1;
    tick;
    in_valid = 0; in_hilo_wr = 0;
    chk("rw_wait", {31'b0, EX_Stall}, 1);
    chk("rw_held", {31'b0, m_valid}, 1);
    #1;
    reset = 1;
    sb.delete();
    #1;
    chk("rw_stall", {31'b0, EX_Stall}, 0);
    chk("rw_mvalid", {31'b0, m_valid}, 0);
    chk("rw_mresult", m_result, 0);
    chk("rw_ov", {24'b0, ov_count}, 0);
    chk("rw_hi", hi_reg, 0);
    ALU_Stall = 0; m_ready = 1;
    tick;
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("rw_noemerge", {31'b0, m_valid}, 0);
    end
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
